// File: rtl/dp_ram_pkg.sv
// Shared constants and helpers for the dual-port asynchronous-read register-file RAM.
package dp_ram_pkg;

  localparam int DP_RAM_DEF_DATA_WIDTH = 8;
  localparam int DP_RAM_DEF_DEPTH      = 1000;

  // Depth need not be a power of two, so the top address codes can be unused.
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/dp_ram_async_read.sv
// True dual-port flop-based RAM: synchronous writes on both ports, combinational reads,
// asynchronous clear. Port A wins a same-address write collision.
module dp_ram_async_read
  import dp_ram_pkg::*;
#(
  parameter int   DATA_WIDTH = DP_RAM_DEF_DATA_WIDTH,
  parameter int   MEM_DEPTH  = DP_RAM_DEF_DEPTH,
  localparam int  ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b
);

  // There is no handshake: each port accepts one operation per clock, unconditionally.

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

  logic in_range_a;
  logic in_range_b;

  assign in_range_a = addr_in_range(32'(addr_a), 32'(MEM_DEPTH));
  assign in_range_b = addr_in_range(32'(addr_b), 32'(MEM_DEPTH));

  // B is applied first so that A overwrites it when both target the same word.
  always_comb begin
    mem_d = mem_q;
    if (we_b && in_range_b) begin
      mem_d[addr_b] = din_b;
    end
    if (we_a && in_range_a) begin
      mem_d[addr_a] = din_a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    dout_a = '0;
    if (!rst && in_range_a) begin
      dout_a = mem_q[addr_a];
    end
  end

  always_comb begin
    dout_b = '0;
    if (!rst && in_range_b) begin
      dout_b = mem_q[addr_b];
    end
  end

endmodule

// File: tb/tb_dp_ram_async_read.sv
// Directed scoreboard bench for dp_ram_async_read: the driver queues expected read data,
// a separate monitor samples both read ports and compares.
module tb_dp_ram_async_read;

  localparam int DW = 8;
  localparam int AW = 10;

  logic          clk;
  logic          rst;
  logic          we_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] din_a;
  logic [DW-1:0] dout_a;
  logic          we_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] din_b;
  logic [DW-1:0] dout_b;

  logic [2*DW-1:0] exp_q[$];
  string           name_q[$];
  int              checks;
  int              errors;
  int              issued;
  int              mon_cnt;
  event            sample_ev;

  dp_ram_async_read dut (
    .clk    (clk),
    .rst    (rst),
    .we_a   (we_a),
    .addr_a (addr_a),
    .din_a  (din_a),
    .dout_a (dout_a),
    .we_b   (we_b),
    .addr_b (addr_b),
    .din_b  (din_b),
    .dout_b (dout_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // monitor: the read ports are combinational, so it samples on request, 1 time unit later
  initial begin
    forever begin
      @(sample_ev);
      #1;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor: sample requested with empty expected queue");
      end else begin
        logic [2*DW-1:0] e;
        string           n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if ({dout_a, dout_b} !== e) begin
          errors++;
          $display("FAIL %s: got dout_a=%02h dout_b=%02h, expected dout_a=%02h dout_b=%02h",
                   n, dout_a, dout_b, e[2*DW-1:DW], e[DW-1:0]);
        end
      end
      mon_cnt++;
    end
  end

  // driver tasks
  task automatic drive(input logic wa, input int aa, input int da,
                       input logic wb, input int ab, input int db);
    we_a   = wa;
    addr_a = AW'(aa);
    din_a  = DW'(da);
    we_b   = wb;
    addr_b = AW'(ab);
    din_b  = DW'(db);
  endtask

  task automatic expect_rd(input string n, input int ea, input int eb);
    int t;
    exp_q.push_back({DW'(ea), DW'(eb)});
    name_q.push_back(n);
    issued++;
    -> sample_ev;
    t = 0;
    while (mon_cnt != issued && t < 50) begin
      #1;
      t++;
    end
    if (mon_cnt != issued) begin
      errors++;
      $display("FAIL %s: monitor timeout, handled %0d of %0d samples", n, mon_cnt, issued);
      mon_cnt = issued;
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    issued  = 0;
    mon_cnt = 0;
    rst     = 1'b1;
    drive(1'b0, 0, 0, 1'b0, 0, 0);
    #12;

    // reset state
    drive(1'b0, 'h000, 0, 1'b0, 'h3E7, 0);
    expect_rd("reset_read", 'h00, 'h00);
    drive(1'b1, 'h006, 'h12, 1'b1, 'h3E7, 'h34);
    after_edge();
    expect_rd("write_during_reset", 'h00, 'h00);
    @(negedge clk);
    drive(1'b0, 0, 0, 1'b0, 0, 0);
    rst = 1'b0;

    // asynchronous clear mid-run
    @(negedge clk);
    drive(1'b1, 5, 'h5A, 1'b0, 5, 0);
    after_edge();
    expect_rd("write_5A_addr5", 'h5A, 'h5A);
    #1;
    rst = 1'b1;
    expect_rd("async_clear_addr5", 'h00, 'h00);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 5, 0, 1'b0, 5, 0);
    #1;
    expect_rd("after_clear_addr5", 'h00, 'h00);

    // single-edge dual write
    @(negedge clk);
    drive(1'b1, 'h001, 'hAA, 1'b1, 'h002, 'hBB);
    @(negedge clk);
    drive(1'b0, 'h001, 0, 1'b0, 'h002, 0);
    #1;
    expect_rd("dual_write_read", 'hAA, 'hBB);
    drive(1'b0, 'h002, 0, 1'b0, 'h001, 0);
    #1;
    expect_rd("dual_write_swapped", 'hBB, 'hAA);

    // write held for two edges, with a pre-edge sample
    @(negedge clk);
    drive(1'b1, 'h003, 'h11, 1'b1, 'h004, 'h22);
    #1;
    expect_rd("pre_edge_old_data", 'h00, 'h00);
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 'h003, 0, 1'b0, 'h004, 0);
    #1;
    expect_rd("held_write_read", 'h11, 'h22);

    // same-address write collision: A wins
    @(negedge clk);
    drive(1'b1, 'h010, 'h33, 1'b1, 'h010, 'h44);
    @(negedge clk);
    drive(1'b0, 'h010, 0, 1'b0, 'h010, 0);
    #1;
    expect_rd("collision_a_wins", 'h33, 'h33);

    // A writes while B reads the same word
    @(negedge clk);
    drive(1'b1, 'h020, 'h77, 1'b0, 'h020, 0);
    #1;
    expect_rd("wr_a_rd_b_before_edge", 'h00, 'h00);
    after_edge();
    expect_rd("wr_a_rd_b_after_edge", 'h77, 'h77);

    // B writes while A reads the same word
    @(negedge clk);
    drive(1'b0, 'h021, 0, 1'b1, 'h021, 'h5C);
    #1;
    expect_rd("wr_b_rd_a_before_edge", 'h00, 'h00);
    after_edge();
    expect_rd("wr_b_rd_a_after_edge", 'h5C, 'h5C);

    // boundaries: last valid word, then out-of-range writes on both ports
    @(negedge clk);
    drive(1'b1, 'h3E7, 'h99, 1'b0, 'h3E7, 0);
    @(negedge clk);
    drive(1'b0, 'h3E7, 0, 1'b0, 'h3E7, 0);
    #1;
    expect_rd("last_word_999", 'h99, 'h99);
    drive(1'b0, 'h000, 0, 1'b1, 'h3E8, 'hEE);
    @(negedge clk);
    drive(1'b1, 'h3FF, 'hD7, 1'b0, 'h3E7, 0);
    @(negedge clk);
    drive(1'b0, 'h3E8, 0, 1'b0, 'h3FF, 0);
    #1;
    expect_rd("out_of_range_reads_zero", 'h00, 'h00);
    drive(1'b0, 'h000, 0, 1'b0, 'h3E7, 0);
    #1;
    expect_rd("oor_no_alias_0_999", 'h00, 'h99);
    drive(1'b0, 'h017, 0, 1'b0, 'h3E8 & 'h1FF, 0);
    #1;
    expect_rd("oor_no_wrap_23_488", 'h00, 'h00);

    // earlier words survive later traffic
    drive(1'b0, 'h001, 0, 1'b0, 'h004, 0);
    #1;
    expect_rd("retention_1_4", 'hAA, 'h22);

    #20;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left in queue, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_ram_async_read.md
Name: dp_ram_async_read

Overview:
- True dual-port register-file RAM with two independent read/write ports (A and B) sharing one clock.
- Writes are synchronous on the rising edge of clk. Reads are asynchronous: dout follows addr combinationally.
- Used as small shared storage between two agents, for example a producer/consumer pair or a scratchpad.
- Memory is built from flip-flops so that asynchronous reset can clear every location.

Parameters:
- DATA_WIDTH, 8, width of each memory word in bits.
- MEM_DEPTH, 1000, number of words. Need not be a power of two.
- ADDR_WIDTH, $clog2(MEM_DEPTH) (10 at default), address width. Derived; not to be overridden independently.

Ports:
- clk  in  1  rising-edge clock for all writes.
- rst  in  1  asynchronous, active-high reset.
- we_a  in  1  port A write enable.
- addr_a  in  ADDR_WIDTH  port A address, used for both read and write.
- din_a  in  DATA_WIDTH  port A write data.
- dout_a  out  DATA_WIDTH  port A read data, combinational.
- we_b  in  1  port B write enable.
- addr_b  in  ADDR_WIDTH  port B address.
- din_b  in  DATA_WIDTH  port B write data.
- dout_b  out  DATA_WIDTH  port B read data, combinational.

Behaviour:
- Reset: rst high clears every memory location to 0 immediately, with no clock required.
  - While rst is high, writes are ignored and dout_a/dout_b read 0.
  - Deassertion of rst is assumed synchronous to clk externally. The first write can occur on the first rising edge after rst falls.
- Write: on a rising clk edge with we_x=1 and addr_x < MEM_DEPTH, mem[addr_x] <= din_x.
  - Write latency is 1 edge.
  - Ports A and B write independently in the same cycle when their addresses differ.
- Read: dout_x = mem[addr_x] combinationally, with zero cycles of latency.
  - A write is visible on both ports in the same delta after the clock edge that performs it.
  - Before that edge, dout shows the old contents, i.e. read-before-write within a cycle.
- Out-of-range address (addr_x >= MEM_DEPTH, e.g. 1000..1023 at default):
  - A write on that port is dropped with no aliasing or wrap.
  - dout_x reads 0.
- Write collision: we_a=1, we_b=1 and addr_a==addr_b (in range) on the same edge.
  - Port A wins: din_a is stored and din_b is discarded.
  - Deterministic; no X is produced.
- Read collision: both ports reading the same address is legal, and both return the same data.
- One port writing while the other reads the same address: the reader sees old data until the edge, then new data.
- No handshake, no stall, no busy output. Every cycle accepts a new operation on each port.
- X/Z on we_x is not required to be handled; the bench shall drive known values.

Decomposition:
- Package dp_ram_pkg:
  - DP_RAM_DEF_DATA_WIDTH=8 and DP_RAM_DEF_DEPTH=1000 constants.
  - Function addr_in_range(addr, depth) returning 1 bit.
- Single module; no sub-module needed.
  - Memory array, collision priority and range checks all live in dp_ram_async_read.
  - Write logic is one always_ff with asynchronous reset; read muxes are two always_comb blocks.

Test Plan:
- Reset, then read addr_a=0x000 and addr_b=0x3E7 -> dout_a=0x00, dout_b=0x00. Assert rst mid-run after writing 0x5A at addr 5, without a clock edge -> dout at addr 5 reads 0x00 immediately.
- Single-edge dual write: we_a=we_b=1, addr_a=0x001/din_a=0xAA, addr_b=0x002/din_b=0xBB for one edge. Then we=0 and read addr_a=0x001, addr_b=0x002 -> dout_a=0xAA, dout_b=0xBB. Swapping addresses gives dout_a=0xBB, dout_b=0xAA.
- Simultaneous write held for 2 edges: addr_a=0x003/0x11, addr_b=0x004/0x22. Then read -> dout_a=0x11, dout_b=0x22. A pre-edge sample at the same addresses -> prior contents (0x00).
- Collision: both ports write addr 0x010, din_a=0x33 and din_b=0x44 -> both ports read 0x33 at 0x010.
- Write-A/read-B same address: port B holds addr 0x020 while A writes 0x77 -> dout_b=0x00 before the edge and 0x77 right after the edge, with no clock needed for the read.
- Boundary: write 0x99 at addr 0x3E7 (999) -> reads 0x99. Write 0xEE at addr 0x3E8 (1000) -> dout=0x00 at 0x3E8, and addr 0x000 and 0x3E7 are unchanged.
